// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encoding
// and default geometry.
package univ_shift_reg_pkg;

  localparam int MODE_W      = 3;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SHAMT_W = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ASR  = 3'd4,
    MODE_ROL  = 3'd5,
    MODE_ROR  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_e;

endpackage

// File: rtl/univ_shift_reg_shift_core.sv
// Combinational shift/rotate datapath: given the current register and carry,
// produces the next value for the shift and rotate modes (others hold).
module univ_shift_reg_shift_core
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic [WIDTH-1:0]   i_q,
  input  logic               i_carry,
  input  mode_e              i_mode,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_sin,
  output logic [WIDTH-1:0]   o_next_q,
  output logic               o_next_carry
);

  localparam logic [SHAMT_W-1:0] W_AMT = SHAMT_W'(WIDTH);

  logic               w_over;
  logic [SHAMT_W-1:0] w_kc;
  logic [SHAMT_W-1:0] w_rot;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shl_q;
  logic [WIDTH-1:0]   w_shr_q;
  logic [WIDTH-1:0]   w_rol_q;
  logic [WIDTH-1:0]   w_ror_q;
  logic               w_shl_c;
  logic               w_shr_c;

  // Amounts past WIDTH behave like WIDTH for the data, but only drop the carry
  // to zero when strictly beyond WIDTH (nothing real was shifted out last).
  assign w_over = (i_shamt > W_AMT);
  assign w_kc   = (i_shamt >= W_AMT) ? W_AMT : i_shamt;
  assign w_rot  = i_shamt % W_AMT;
  assign w_fill = (i_mode == MODE_ASR) ? i_q[WIDTH-1] : i_sin;

  assign w_shl_q = WIDTH'(({i_q, {WIDTH{w_fill}}} << w_kc) >> WIDTH);
  assign w_shl_c = 1'(({1'b0, i_q, {WIDTH{1'b0}}} << w_kc) >> (2 * WIDTH));
  assign w_shr_q = WIDTH'(({{WIDTH{w_fill}}, i_q, 1'b0} >> w_kc) >> 1);
  assign w_shr_c = 1'({i_q, 1'b0} >> w_kc);
  assign w_rol_q = WIDTH'(({i_q, i_q} << w_rot) >> WIDTH);
  assign w_ror_q = WIDTH'({i_q, i_q} >> w_rot);

  // Select the result for the active mode; a zero amount leaves everything as is.
  always_comb begin
    o_next_q     = i_q;
    o_next_carry = i_carry;
    if (i_shamt != {SHAMT_W{1'b0}}) begin
      case (i_mode)
        MODE_SHL: begin
          o_next_q     = w_shl_q;
          o_next_carry = w_over ? 1'b0 : w_shl_c;
        end
        MODE_SHR: begin
          o_next_q     = w_shr_q;
          o_next_carry = w_over ? 1'b0 : w_shr_c;
        end
        MODE_ASR: begin
          o_next_q     = w_shr_q;
          o_next_carry = w_shr_c;
        end
        MODE_ROL: begin
          o_next_q     = w_rol_q;
          o_next_carry = w_rol_q[0];
        end
        MODE_ROR: begin
          o_next_q     = w_ror_q;
          o_next_carry = w_ror_q[WIDTH-1];
        end
        default: begin
          o_next_q     = i_q;
          o_next_carry = i_carry;
        end
      endcase
    end else begin
      o_next_q     = i_q;
      o_next_carry = i_carry;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: parallel load, clear, shifts and rotates with enable,
// registered carry-out and a zero flag derived directly from the register.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [MODE_W-1:0]  mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   d,
  input  logic               sin,
  output logic [WIDTH-1:0]   q,
  output logic               carry,
  output logic               zero
);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  mode_e            w_mode;
  logic [WIDTH-1:0] w_core_q;
  logic             w_core_carry;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_carry;

  assign w_mode = mode_e'(mode);

  univ_shift_reg_shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .i_q          (r_q),
    .i_carry      (r_carry),
    .i_mode       (w_mode),
    .i_shamt      (shamt),
    .i_sin        (sin),
    .o_next_q     (w_core_q),
    .o_next_carry (w_core_carry)
  );

  // Load and clear bypass the shifter; everything else comes from the core.
  always_comb begin
    w_next_q     = w_core_q;
    w_next_carry = w_core_carry;
    case (w_mode)
      MODE_LOAD: begin
        w_next_q     = d;
        w_next_carry = r_carry;
      end
      MODE_CLR: begin
        w_next_q     = {WIDTH{1'b0}};
        w_next_carry = 1'b0;
      end
      default: begin
        w_next_q     = w_core_q;
        w_next_carry = w_core_carry;
      end
    endcase
  end

  // State register with asynchronous clear and enable gating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
    end else if (en) begin
      r_q     <= w_next_q;
      r_carry <= w_next_carry;
    end else begin
      r_q     <= r_q;
      r_carry <= r_carry;
    end
  end

  assign q     = r_q;
  assign carry = r_carry;
  assign zero  = (r_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, SHAMT_W=4): an arithmetic
// reference model checked every cycle, plus hand-computed expectations.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [3:0] shamt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic       carry;
  logic       zero;

  logic [7:0] m_q = 8'h00;
  logic       m_c = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(8), .SHAMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .shamt (shamt),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .carry (carry),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_state(input string nm, input logic [7:0] eq, input logic ec);
    chk({nm, "_q"}, {24'h0, q}, {24'h0, eq});
    chk({nm, "_carry"}, {31'h0, carry}, {31'h0, ec});
    chk({nm, "_zero"}, {31'h0, zero}, {31'h0, (eq == 8'h00)});
  endtask

  // Reference: each mode's rule written as integer arithmetic on the old value.
  function automatic logic [8:0] model_next(input logic [7:0] oq, input logic oc,
                                            input logic [2:0] md, input logic [3:0] k,
                                            input logic [7:0] dv, input logic s);
    int qi, ki, r, n, nc, fill;
    qi = int'(oq);
    ki = int'(k);
    n  = qi;
    nc = int'(oc);
    fill = 0;
    case (md)
      3'd1: n = int'(dv);
      3'd7: begin n = 0; nc = 0; end
      3'd2: if (ki != 0) begin
        if (ki < W) n = ((qi << ki) | (s ? (1 << ki) - 1 : 0)) & 255;
        else        n = s ? 255 : 0;
        nc = (ki <= W) ? (qi >> (W - ki)) & 1 : 0;
      end
      3'd3, 3'd4: if (ki != 0) begin
        fill = (md == 3'd4) ? (qi >> (W - 1)) & 1 : int'(s);
        if (ki < W) n = (qi >> ki) | ((fill != 0) ? (255 << (W - ki)) & 255 : 0);
        else        n = (fill != 0) ? 255 : 0;
        if (md == 3'd4 && ki >= W) nc = fill;
        else                       nc = (ki <= W) ? (qi >> (ki - 1)) & 1 : 0;
      end
      3'd5: if (ki != 0) begin
        r  = ki % W;
        n  = ((qi << r) | (qi >> (W - r))) & 255;
        nc = n & 1;
      end
      3'd6: if (ki != 0) begin
        r  = ki % W;
        n  = ((qi >> r) | (qi << (W - r))) & 255;
        nc = (n >> (W - 1)) & 1;
      end
      default: n = qi;
    endcase
    return {1'(nc), 8'(n)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= 8'h00;
      m_c <= 1'b0;
    end else if (en) begin
      {m_c, m_q} <= model_next(m_q, m_c, mode, shamt, d, sin);
    end
  end

  always @(negedge clk) begin
    chk("cmp_q", {24'h0, q}, {24'h0, m_q});
    chk("cmp_carry", {31'h0, carry}, {31'h0, m_c});
    chk("cmp_zero", {31'h0, zero}, {31'h0, (m_q == 8'h00)});
  end

  task automatic op(input mode_e m, input logic [3:0] k, input logic [7:0] dv, input logic s);
    @(negedge clk);
    mode  = m;
    shamt = k;
    d     = dv;
    sin   = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    mode  = MODE_HOLD;
    shamt = 4'd0;
    d     = 8'h00;
    sin   = 1'b0;
    #7;
    expect_state("reset", 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;

    op(MODE_LOAD, 4'd0, 8'hA5, 1'b0); expect_state("load_a5", 8'hA5, 1'b0);
    op(MODE_SHL, 4'd1, 8'h00, 1'b0);  expect_state("shl1_a5", 8'h4A, 1'b1);
    #2 reset = 1'b0;
    #1 expect_state("async_rst", 8'h00, 1'b0);
    mode = MODE_HOLD;
    @(negedge clk);
    reset = 1'b1;

    op(MODE_LOAD, 4'd0, 8'h81, 1'b0); expect_state("load_81", 8'h81, 1'b0);
    op(MODE_SHL, 4'd1, 8'h00, 1'b0);  expect_state("shl1", 8'h02, 1'b1);
    op(MODE_LOAD, 4'd0, 8'h55, 1'b0);
    op(MODE_SHL, 4'd8, 8'h00, 1'b1);  expect_state("shl8_sin1", 8'hFF, 1'b1);
    op(MODE_LOAD, 4'd0, 8'h90, 1'b0);
    op(MODE_ASR, 4'd3, 8'h00, 1'b1);  expect_state("asr3", 8'hF2, 1'b0);
    op(MODE_ASR, 4'd12, 8'h00, 1'b0); expect_state("asr12", 8'hFF, 1'b1);
    op(MODE_LOAD, 4'd0, 8'h01, 1'b0);
    op(MODE_ROR, 4'd9, 8'h00, 1'b0);  expect_state("ror9", 8'h80, 1'b1);
    op(MODE_ROL, 4'd8, 8'h00, 1'b1);  expect_state("rol8", 8'h80, 1'b0);

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op(MODE_LOAD, 4'd0, 8'h3C, 1'b0); expect_state("en_low", 8'h80, 1'b0);
    end
    en = 1'b1;
    op(MODE_LOAD, 4'd0, 8'h3C, 1'b0); expect_state("en_high", 8'h3C, 1'b0);

    op(MODE_SHL, 4'd3, 8'h00, 1'b0);  expect_state("shl3", 8'hE0, 1'b1);
    op(MODE_SHL, 4'd0, 8'h00, 1'b1);  expect_state("shl0", 8'hE0, 1'b1);
    op(MODE_SHR, 4'd0, 8'h00, 1'b1);  expect_state("shr0", 8'hE0, 1'b1);
    op(MODE_ASR, 4'd0, 8'h00, 1'b0);  expect_state("asr0", 8'hE0, 1'b1);
    op(MODE_ROL, 4'd0, 8'h00, 1'b0);  expect_state("rol0", 8'hE0, 1'b1);
    op(MODE_ROR, 4'd0, 8'h00, 1'b0);  expect_state("ror0", 8'hE0, 1'b1);
    op(MODE_CLR, 4'd5, 8'h77, 1'b1);  expect_state("clr", 8'h00, 1'b0);

    op(MODE_LOAD, 4'd0, 8'hC3, 1'b0);
    op(MODE_SHR, 4'd8, 8'h00, 1'b0);  expect_state("shr8", 8'h00, 1'b1);
    op(MODE_LOAD, 4'd0, 8'hC3, 1'b0);
    op(MODE_SHR, 4'd9, 8'h00, 1'b1);  expect_state("shr9", 8'hFF, 1'b0);
    op(MODE_SHR, 4'd2, 8'h00, 1'b0);  expect_state("shr2", 8'h3F, 1'b1);
    op(MODE_LOAD, 4'd0, 8'h81, 1'b0);
    op(MODE_ROR, 4'd10, 8'h00, 1'b0); expect_state("ror10", 8'h60, 1'b0);
    op(MODE_ROL, 4'd1, 8'h00, 1'b0);  expect_state("rol1", 8'hC0, 1'b0);
    op(MODE_ROL, 4'd2, 8'h00, 1'b0);  expect_state("rol2", 8'h03, 1'b1);
    op(MODE_LOAD, 4'd0, 8'h40, 1'b0);
    op(MODE_ASR, 4'd8, 8'h00, 1'b1);  expect_state("asr8_pos", 8'h00, 1'b0);
    op(MODE_LOAD, 4'd0, 8'h80, 1'b0);
    op(MODE_ASR, 4'd15, 8'h00, 1'b0); expect_state("asr15_neg", 8'hFF, 1'b1);
    op(MODE_LOAD, 4'd0, 8'h81, 1'b0);
    op(MODE_SHL, 4'd15, 8'h00, 1'b0); expect_state("shl15", 8'h00, 1'b0);
    op(MODE_LOAD, 4'd0, 8'h81, 1'b0);
    op(MODE_SHL, 4'd4, 8'h00, 1'b1);  expect_state("shl4_sin1", 8'h1F, 1'b0);
    op(MODE_HOLD, 4'd3, 8'hAA, 1'b1); expect_state("hold", 8'h1F, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal register: multi-mode shifter/rotator with parallel load, enable, serial fill, carry-out and zero flag.
- Generalises the single-bit enabled storage element to WIDTH bits with a per-cycle shift amount.
- Drop-in datapath building block for serialisers, barrel-shift ALU stages and LFSR-style scratch logic.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- SHAMT_W, 4, width of the shamt input; must satisfy 2**SHAMT_W > WIDTH so over-range shifts are reachable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; when low, all state holds.
- mode  input  3  operation select, encoded as in Behaviour.
- shamt  input  SHAMT_W  shift/rotate amount, unsigned.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial fill bit for the vacated positions of SHL/SHR.
- q  output  WIDTH  register contents.
- carry  output  1  last bit shifted or rotated out (registered).
- zero  output  1  high when q == 0 (combinational from q).

Behaviour:
- Reset: reset low asynchronously forces q=0 and carry=0, so zero=1. This takes effect immediately, including mid-operation. Release is synchronous to the next clk edge, and an operation presented on that edge executes normally.
- Latency: one cycle. The result of mode/shamt/d/sin sampled at a rising edge appears on q and carry right after that edge.
- en=0: q and carry hold regardless of mode.
- Mode encoding: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR, 7 CLR.
- HOLD: no change.
- LOAD: q<=d; carry unchanged.
- CLR: q<=0; carry<=0.
- shamt=0 in any shift or rotate mode: q and carry unchanged.
- SHL with k=shamt:
  - k<WIDTH: q<={q[WIDTH-1-k:0], k copies of sin}.
  - k>=WIDTH: q<=all sin.
  - carry<=old q[WIDTH-k] if k<=WIDTH, else 0.
- SHR with k=shamt:
  - k<WIDTH: q<={k copies of sin, q[WIDTH-1:k]}.
  - k>=WIDTH: q<=all sin.
  - carry<=old q[k-1] if k<=WIDTH, else 0.
- ASR:
  - Fill uses old q[WIDTH-1]; sin is ignored.
  - k>=WIDTH: q<=all sign, carry<=sign.
  - Otherwise carry<=old q[k-1].
- ROL/ROR:
  - Effective amount is k mod WIDTH; WIDTH need not be a power of two.
  - ROL: carry<=new q[0]. ROR: carry<=new q[WIDTH-1].
  - This carry rule also applies when k mod WIDTH = 0 with k != 0; in that case q is unchanged.
- zero: combinational from q only, never registered separately, so it can never lag q.
- Forbidden: latches, and any use of sin outside SHL/SHR.

Decomposition:
- Shared package: mode enum (typedef, 3-bit) with the encoding above, plus constants MODE_W=3 and default WIDTH/SHAMT_W.
- Sub-module shift_core: purely combinational; takes q, mode, shamt and sin, produces next_q and next_carry.
- Top module: holds the register, the enable/reset handling and the zero flag.

Test Plan (WIDTH=8, SHAMT_W=4):
- Reset low mid-cycle while q=0xA5 -> q=0x00, carry=0, zero=1 immediately, without waiting for a clk edge.
- LOAD d=0x81, then SHL shamt=1 sin=0 -> q=0x02, carry=1. Then SHL shamt=8 sin=1 from a loaded 0x55 -> q=0xFF, carry=1.
- LOAD 0x90, ASR shamt=3 -> q=0xF2, carry=0. Then ASR shamt=12 -> q=0xFF, carry=1.
- LOAD 0x01, ROR shamt=9 -> q=0x80, carry=1. Then ROL shamt=8 -> q=0x80, carry=0.
- en=0 with mode=LOAD d=0x3C over 3 cycles -> q and carry unchanged. Raise en -> q=0x3C on the next edge.
- Shift modes with shamt=0 -> q and carry unchanged. Then CLR -> q=0, carry=0, zero=1.
